// File: rtl/vga_gray_source.sv
// vga_gray_source: 640x480@60 timing plus centered RGB565 ROM image as 8-bit luma; pixel_clk/n_rst in, rom_addr/rom_data ROM port, gray_out/h_pos/v_pos/de/hsync/vsync/frame_start aligned 3 cycles after counters
module vga_gray_source #(
  parameter int WIDTH = 534,
  parameter int HEIGHT = 400,
  parameter logic [7:0] BG_GRAY = 8'd0,
  localparam int AW = $clog2(WIDTH*HEIGHT)
) (
  input  logic          pixel_clk,
  input  logic          n_rst,
  output logic [AW-1:0] rom_addr,
  input  logic [15:0]   rom_data,
  output logic [7:0]    gray_out,
  output logic [9:0]    h_pos,
  output logic [9:0]    v_pos,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic          frame_start
);
  localparam logic [9:0] NW = 10'((640-WIDTH)/2);
  localparam logic [9:0] NH = 10'((480-HEIGHT)/2);
  localparam logic [23:0] META_RST = 24'h6;
  logic [9:0] hc, vc, h_off, v_off;
  logic in_win, started, win1, win2;
  logic [23:0] meta, m1, m2, m3;
  logic [7:0] r8, g8, b8;
  logic [15:0] acc;
  always_comb begin
    h_off = hc - NW;
    v_off = vc - NH;
    in_win = h_off < 10'(WIDTH) && v_off < 10'(HEIGHT);
    meta = {hc, vc, hc < 10'd640 && vc < 10'd480, !(hc >= 10'd656 && hc < 10'd752),
            !(vc >= 10'd490 && vc < 10'd492), hc == 10'd0 && vc == 10'd0};
    r8 = {rom_data[15:11], rom_data[15:13]};
    g8 = {rom_data[10:5], rom_data[10:9]};
    b8 = {rom_data[4:0], rom_data[4:2]};
    acc = 16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8} + 16'd29 * {8'd0, b8};
  end
  assign {h_pos, v_pos, de, hsync, vsync, frame_start} = m3;
  always_ff @(posedge pixel_clk or negedge n_rst)
    if (!n_rst) begin
      hc <= '0;
      vc <= '0;
      rom_addr <= '0;
      started <= 1'b0;
      win1 <= 1'b0;
      win2 <= 1'b0;
      m1 <= META_RST;
      m2 <= META_RST;
      m3 <= META_RST;
      gray_out <= 8'd0;
    end else begin
      hc <= hc == 10'd799 ? '0 : hc + 10'd1;
      vc <= hc != 10'd799 ? vc : vc == 10'd524 ? '0 : vc + 10'd1;
      if (in_win) begin
        rom_addr <= started && !meta[0] ? rom_addr + AW'(1) : '0;
        started <= 1'b1;
      end else if (meta[0]) begin
        rom_addr <= '0;
        started <= 1'b0;
      end
      win1 <= in_win;
      win2 <= win1;
      m1 <= meta;
      m2 <= m1;
      m3 <= m2;
      gray_out <= win2 ? acc[15:8] : m2[3] ? BG_GRAY : 8'd0;
    end
endmodule
